// File: rtl/vm_pkg.sv
// Shared types and widths for the vending-machine input controller.
package vm_pkg;

  localparam int unsigned COIN_W = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned DROP_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    BUY_WAIT = 2'd2
  } vm_state_e;

  // Adds up to two discarded presses to the drop counter, saturating at all-ones.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] cnt,
                                                input logic [1:0]        n);
    logic [DROP_W:0] sum;
    sum = {1'b0, cnt} + {{(DROP_W-1){1'b0}}, n};
    if (sum[DROP_W]) begin
      return {DROP_W{1'b1}};
    end
    return sum[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/vm_input_ctrl_if.sv
// Command interface between the input controller (master) and the vending core (slave).
interface vm_input_ctrl_if;
  import vm_pkg::*;

  logic [COIN_W-1:0] b_in;
  logic              load;
  logic              buy;
  logic [SEL_W-1:0]  sel;
  logic              yes;
  logic              no;

  modport master (output b_in, load, buy, sel, input yes, no);
  modport slave  (input b_in, load, buy, sel, output yes, no);

endinterface

// File: rtl/btn_debounce.sv
// Raw button -> synchronised, debounced level -> single-cycle rising-edge pulse.
// The stability counter is present only when VM_DEBOUNCE_EN is defined.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  logic [1:0] sync_q;
  logic       level_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

`ifdef VM_DEBOUNCE_EN
  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  logic [CntW-1:0] cnt_q;

  // Level flips only after the synchronised input has disagreed with it for DEB_CYCLES cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (sync_q[1] == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q >= CntW'(DEB_CYCLES - 1)) begin
      cnt_q   <= '0;
      level_q <= sync_q[1];
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_deb;
  assign unused_deb = ^DEB_CYCLES;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= sync_q[1];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level_q;
    end
  end

  assign pulse = level_q & ~prev_q;

endmodule

// File: rtl/vm_input_ctrl.sv
// Board-input front end: turns buttons/switches into load/buy commands for the vending core.
// Build option: VM_DEBOUNCE_EN enables the per-button stability counters.
module vm_input_ctrl
  import vm_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 1000000,
  parameter int unsigned RESP_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_btn,
  input  logic [COIN_W-1:0]   coin_val,
  input  logic                buy_btn,
  input  logic [SEL_W-1:0]    sel_sw,
  vm_input_ctrl_if.master     cmd,
  output logic                busy,
  output logic                timeout,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam int unsigned TmoW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT + 1) : 1;

  logic              coin_ev;
  logic              buy_ev;
  logic [COIN_W-1:0] coin_val_q1, coin_val_s;
  logic [SEL_W-1:0]  sel_sw_q1, sel_sw_s;

  vm_state_e         state_q;
  logic [COIN_W-1:0] b_in_q;
  logic              load_q;
  logic              buy_q;
  logic [SEL_W-1:0]  sel_q;
  logic              busy_q;
  logic              timeout_q;
  logic [DROP_W-1:0] drop_q;
  logic [TmoW-1:0]   tmo_cnt_q;

  logic              coin_ok;
  logic [1:0]        n_ev;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_coin_deb (
    .clk   (clk),
    .rst   (rst),
    .raw   (coin_btn),
    .pulse (coin_ev)
  );

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_buy_deb (
    .clk   (clk),
    .rst   (rst),
    .raw   (buy_btn),
    .pulse (buy_ev)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coin_val_q1 <= '0;
      coin_val_s  <= '0;
      sel_sw_q1   <= '0;
      sel_sw_s    <= '0;
    end else begin
      coin_val_q1 <= coin_val;
      coin_val_s  <= coin_val_q1;
      sel_sw_q1   <= sel_sw;
      sel_sw_s    <= sel_sw_q1;
    end
  end

  // A zero-value coin is treated as no coin at all.
  assign coin_ok = coin_ev && (coin_val_s != '0);
  assign n_ev    = {1'b0, coin_ev} + {1'b0, buy_ev};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      b_in_q    <= '0;
      load_q    <= 1'b0;
      buy_q     <= 1'b0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      drop_q    <= '0;
      tmo_cnt_q <= '0;
    end else begin
      load_q <= 1'b0;
      buy_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (coin_ok) begin
            state_q <= LOAD;
            load_q  <= 1'b1;
            b_in_q  <= coin_val_s;
            if (buy_ev) begin
              drop_q <= sat_inc(drop_q, 2'd1);
            end
          end else if (buy_ev) begin
            state_q   <= BUY_WAIT;
            buy_q     <= 1'b1;
            busy_q    <= 1'b1;
            sel_q     <= sel_sw_s;
            timeout_q <= 1'b0;
            tmo_cnt_q <= '0;
          end
        end
        LOAD: begin
          state_q <= IDLE;
          b_in_q  <= '0;
          drop_q  <= sat_inc(drop_q, n_ev);
        end
        BUY_WAIT: begin
          drop_q <= sat_inc(drop_q, n_ev);
          if (cmd.yes || cmd.no) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (tmo_cnt_q >= TmoW'(RESP_TIMEOUT - 1)) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd.b_in = b_in_q;
  assign cmd.load = load_q;
  assign cmd.buy  = buy_q;
  assign cmd.sel  = sel_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_vm_input_ctrl.sv
// Directed self-checking bench for vm_input_ctrl (works with or without VM_DEBOUNCE_EN).
module tb_vm_input_ctrl;
  import vm_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              coin_btn = 1'b0;
  logic [COIN_W-1:0] coin_val = '0;
  logic              buy_btn = 1'b0;
  logic [SEL_W-1:0]  sel_sw = '0;
  logic              busy;
  logic              timeout;
  logic [DROP_W-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  int load_cnt = 0;
  int buy_cnt = 0;
  int busy_cycles = 0;
  int last_b_in = 0;
  int base_load, base_buy, base_busy;
  int exp_bounce;

  vm_input_ctrl_if cmd_if ();

  vm_input_ctrl #(
    .DEB_CYCLES   (4),
    .RESP_TIMEOUT (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .coin_btn (coin_btn),
    .coin_val (coin_val),
    .buy_btn  (buy_btn),
    .sel_sw   (sel_sw),
    .cmd      (cmd_if),
    .busy     (busy),
    .timeout  (timeout),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_if.load === 1'b1) begin
      load_cnt++;
      last_b_in = int'(cmd_if.b_in);
    end
    if (cmd_if.buy === 1'b1) buy_cnt++;
    if (busy === 1'b1) busy_cycles++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_buy();
    int n;
    n = 0;
    while (cmd_if.buy !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("buy_seen", {31'd0, cmd_if.buy}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_load"}, {31'd0, cmd_if.load}, 32'd0);
    chk({pfx, "_buy"}, {31'd0, cmd_if.buy}, 32'd0);
    chk({pfx, "_b_in"}, {28'd0, cmd_if.b_in}, 32'd0);
    chk({pfx, "_sel"}, {30'd0, cmd_if.sel}, 32'd0);
    chk({pfx, "_busy"}, {31'd0, busy}, 32'd0);
    chk({pfx, "_timeout"}, {31'd0, timeout}, 32'd0);
    chk({pfx, "_drop"}, {28'd0, drop_cnt}, 32'd0);
  endtask

  initial begin
    cmd_if.yes = 1'b0;
    cmd_if.no  = 1'b0;

    // Reset state
    tick(3);
    chk_reset_vals("rst");
    rst = 1'b1;
    tick(5);

    // Single clean coin press, value 5
    base_load = load_cnt;
    coin_val = 4'd5;
    tick(3);
    coin_btn = 1'b1;
    tick(12);
    coin_btn = 1'b0;
    tick(20);
    chk("coin_load_cnt", load_cnt - base_load, 32'd1);
    chk("coin_b_in", last_b_in, 32'd5);

    // Bouncing coin button, value 3
    base_load = load_cnt;
    coin_val = 4'd3;
    tick(3);
    for (int i = 0; i < 10; i++) begin
      coin_btn = (i % 2 == 0);
      tick(2);
    end
    coin_btn = 1'b1;
    tick(12);
    coin_btn = 1'b0;
    tick(20);
`ifdef VM_DEBOUNCE_EN
    exp_bounce = 1;
`else
    exp_bounce = 6;
`endif
    chk("bounce_load_cnt", load_cnt - base_load, exp_bounce);
    chk("bounce_b_in", last_b_in, 32'd3);
    chk("bounce_drop", {28'd0, drop_cnt}, 32'd0);

    // Buy sel=2, yes 3 cycles after buy
    sel_sw = 2'd2;
    base_buy = buy_cnt;
    base_busy = busy_cycles;
    tick(3);
    buy_btn = 1'b1;
    wait_buy();
    chk("buy_sel", {30'd0, cmd_if.sel}, 32'd2);
    chk("buy_busy", {31'd0, busy}, 32'd1);
    tick(2);
    chk("buy_pulse_over", {31'd0, cmd_if.buy}, 32'd0);
    chk("buy_sel_held", {30'd0, cmd_if.sel}, 32'd2);
    tick();
    cmd_if.yes = 1'b1;
    tick();
    cmd_if.yes = 1'b0;
    chk("buy_busy_fall", {31'd0, busy}, 32'd0);
    buy_btn = 1'b0;
    tick(20);
    chk("buy_busy_len", busy_cycles - base_busy, 32'd4);
    chk("buy_cnt", buy_cnt - base_buy, 32'd1);
    chk("buy_timeout", {31'd0, timeout}, 32'd0);
    chk("buy_sel_after", {30'd0, cmd_if.sel}, 32'd2);

    // Buy with no verdict -> timeout
    sel_sw = 2'd1;
    base_busy = busy_cycles;
    tick(3);
    buy_btn = 1'b1;
    wait_buy();
    tick(8);
    buy_btn = 1'b0;
    tick(30);
    chk("tmo_busy_len", busy_cycles - base_busy, 32'd16);
    chk("tmo_flag", {31'd0, timeout}, 32'd1);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    chk("tmo_sel", {30'd0, cmd_if.sel}, 32'd1);

    // Next buy clears timeout; verdict in the buy cycle itself
    sel_sw = 2'd3;
    base_busy = busy_cycles;
    tick(3);
    buy_btn = 1'b1;
    wait_buy();
    chk("clr_timeout", {31'd0, timeout}, 32'd0);
    cmd_if.no = 1'b1;
    tick();
    cmd_if.no = 1'b0;
    chk("same_cycle_busy", {31'd0, busy}, 32'd0);
    tick(8);
    buy_btn = 1'b0;
    tick(20);
    chk("same_cycle_len", busy_cycles - base_busy, 32'd1);
    chk("same_cycle_tmo", {31'd0, timeout}, 32'd0);

    // Two coin presses while BUY_WAIT -> dropped
    base_load = load_cnt;
    base_buy = buy_cnt;
    coin_val = 4'd9;
    tick(3);
    buy_btn = 1'b1;
    tick();
    coin_btn = 1'b1;
    tick(6);
    coin_btn = 1'b0;
    buy_btn = 1'b0;
    tick(6);
    coin_btn = 1'b1;
    tick(6);
    coin_btn = 1'b0;
    tick(30);
    chk("drop_load_cnt", load_cnt - base_load, 32'd0);
    chk("drop_buy_cnt", buy_cnt - base_buy, 32'd1);
    chk("drop_cnt2", {28'd0, drop_cnt}, 32'd2);

    // Simultaneous coin+buy in IDLE: coin wins, buy dropped; saturate
    base_load = load_cnt;
    base_buy = buy_cnt;
    coin_val = 4'd7;
    for (int i = 0; i < 20; i++) begin
      coin_btn = 1'b1;
      buy_btn = 1'b1;
      tick(12);
      coin_btn = 1'b0;
      buy_btn = 1'b0;
      tick(12);
      if (i == 0) begin
        chk("simul_drop3", {28'd0, drop_cnt}, 32'd3);
        chk("simul_b_in", last_b_in, 32'd7);
      end
    end
    chk("simul_loads", load_cnt - base_load, 32'd20);
    chk("simul_buys", buy_cnt - base_buy, 32'd0);
    chk("drop_sat", {28'd0, drop_cnt}, 32'd15);

    // Reset mid-BUY_WAIT
    sel_sw = 2'd2;
    tick(3);
    buy_btn = 1'b1;
    wait_buy();
    buy_btn = 1'b0;
    tick(2);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk_reset_vals("async");
    tick(3);
    base_load = load_cnt;
    base_buy = buy_cnt;
    rst = 1'b1;
    tick(40);
    chk("post_rst_load", load_cnt - base_load, 32'd0);
    chk("post_rst_buy", buy_cnt - base_buy, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vm_input_ctrl.md
# vm_input_ctrl

Front-end controller that turns raw board inputs (coin button, coin-value switches, product switches, buy button) into the clean single-cycle `load`/`b_in` and `buy`/`sel` commands consumed by the vending machine core. It is the producer side of the core's command interface and sits between board pins and `main`. It also consumes the core's `yes`/`no` verdicts to close the buy handshake. Inputs are synchronised and debounced, with one command in flight at a time.

## Interface
- `DEB_CYCLES`, default 1000000: cycles a raw button must stay stable before its debounced level changes (10 ms at 100 MHz).
- `RESP_TIMEOUT`, default 16: cycles to wait for `yes`/`no` after a `buy` pulse.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `coin_btn` in 1: raw coin-insert button, asynchronous.
- `coin_val` in 4: raw coin-value switches, asynchronous.
- `buy_btn` in 1: raw buy button, asynchronous.
- `sel_sw` in 2: raw product-select switches, asynchronous.
- `yes` in 1: core verdict "vend accepted"; single-cycle pulse or level.
- `no` in 1: core verdict "vend refused"; single-cycle pulse or level.
- `b_in` out 4: coin value for the core; valid while `load`=1.
- `load` out 1: single-cycle coin command.
- `buy` out 1: single-cycle buy command.
- `sel` out 2: product code; held stable from the `buy` pulse until the handshake ends.
- `busy` out 1: high while a buy handshake is outstanding.
- `timeout` out 1: sticky flag, set when no verdict arrives; cleared by the next accepted buy press or reset.
- `drop_cnt` out 4: saturating count of presses discarded while busy.

## Operation
- All raw inputs pass through two-flop synchronisers. `coin_val` and `sel_sw` are sampled only from their synchronised copies.
- Buttons are debounced, then rising-edge detected. Each press yields exactly one internal event, and releases are ignored.
- The FSM has three states:
  - IDLE: a coin event with `coin_val`≠0 moves to LOAD. A coin event with `coin_val`=0 is ignored and not counted. A buy event latches `sel_sw` into `sel`, clears `timeout`, and moves to BUY_WAIT.
  - LOAD: `load`=1 and `b_in`=latched value for exactly one cycle, then return to IDLE.
  - BUY_WAIT: `buy`=1 in the first cycle only, and `busy`=1 throughout. `yes` or `no` sampled high returns to IDLE. If the timeout counter reaches `RESP_TIMEOUT` with no verdict, set `timeout` and return to IDLE.
- Coin and buy events in the same IDLE cycle: the coin wins. The buy event is dropped and `drop_cnt` increments.
- Any event arriving in LOAD or BUY_WAIT is discarded and increments `drop_cnt`, which saturates at 15.
- `yes`/`no` arriving in the `buy` cycle itself are honoured; the next state is IDLE.
- `yes`/`no` seen while in IDLE or LOAD are ignored.
- Reset values: `b_in`=0, `load`=0, `buy`=0, `sel`=0, `busy`=0, `timeout`=0, `drop_cnt`=0, state IDLE. Debouncer levels reset to 0 (released).
- Reset mid-handshake aborts immediately. No pulse is emitted after reset deasserts until a new press is detected.

## Timing
- Raw edge to event: 2 synchroniser cycles + `DEB_CYCLES` + 1 edge-detect cycle.
- Event to `load`/`buy` pulse: 1 cycle (registered outputs).
- `buy` pulse: 1 cycle. `busy` rises with `buy` and falls the cycle after the verdict is sampled.
- Timeout: `busy` is high for at most `RESP_TIMEOUT` cycles. `timeout` rises as `busy` falls.
- Minimum spacing between consecutive `load` pulses is 2 cycles.

## Configuration
- `VM_DEBOUNCE_EN` defined: full debounce counter per button, as above.
- `VM_DEBOUNCE_EN` undefined: debouncers compile out. Buttons use synchroniser + edge detect only, so event latency is 3 cycles and `DEB_CYCLES` is unused. This mode is for simulation and test benches.

## Structure
- Package `vm_pkg` holds:
  - the FSM state enum (IDLE, LOAD, BUY_WAIT);
  - constants `COIN_W`=4, `SEL_W`=2, `DROP_W`=4.
- Sub-module `btn_debounce`: synchroniser, stability counter and rising-edge pulse, instantiated once for `coin_btn` and once for `buy_btn`.
- The FSM, latches and counters live in the top module.

## Test plan
- Coin press with `coin_val`=5 held 3×`DEB_CYCLES` (bench `DEB_CYCLES`=4) → exactly one `load` pulse with `b_in`=5.
- Bouncing `coin_btn` (toggles every 2 cycles for 20 cycles, then stable high) → exactly one `load` pulse.
- Buy with `sel_sw`=2, then `yes` pulsed 3 cycles after `buy` → `sel`=2 held, `busy` high for 4 cycles, `timeout`=0.
- Buy with no verdict (`RESP_TIMEOUT`=16) → `busy` drops after 16 cycles and `timeout`=1. A next buy press clears `timeout`.
- Two coin presses during BUY_WAIT → no `load` pulses and `drop_cnt`=2. After 20 dropped presses, `drop_cnt`=15.
- Assert `rst` low mid-BUY_WAIT → all outputs at reset values asynchronously, with no `buy`/`load` pulse after release.
